// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 8 lines x 16 bytes, one 16-bit word per hit.
// Latency: a hit responds combinationally in the request cycle. A miss responds in the first IDLE cycle after the fill.
// Backpressure: mem_read is held until mem_resp. The fill waits in FILL as long as pmem_resp stays low.
//
// Ports:
//   clk, rst_n           : clock and asynchronous active-low reset
//   mem_read/_address    : fetch-side request (byte address, bit 0 ignored)
//   mem_resp/_rdata      : one-cycle completion pulse and instruction word
//   pmem_read/_address   : line-fill request to physical memory (line aligned)
//   pmem_resp/_rdata     : single-cycle fill data pulse with the 128-bit line
//   hit_count/miss_count : saturating statistics counters
module icache (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic [15:0]  mem_address,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    output logic         pmem_read,
    output logic [15:0]  pmem_address,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_e;

    state_e         state_q;
    logic [11:0]    fill_q;        // latched line address mem_address[15:4]
    logic [7:0]     valid_q;
    logic [8:0]     tag_q  [8];
    logic [127:0]   data_q [8];
    logic [15:0]    hit_cnt_q;
    logic [15:0]    miss_cnt_q;

    logic [8:0]     req_tag;
    logic [2:0]     req_idx;
    logic [2:0]     req_word;
    logic [2:0]     fill_idx;
    logic [127:0]   sel_line;
    logic           hit;
    logic           miss_start;
    logic           fill_done;
    logic           unused_addr_bit0;

    assign req_tag          = mem_address[15:7];
    assign req_idx          = mem_address[6:4];
    assign req_word         = mem_address[3:1];
    assign fill_idx         = fill_q[2:0];
    assign unused_addr_bit0 = mem_address[0];

    // valid_q is reset, so an un-reset tag can never produce a hit.
    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign sel_line   = data_q[req_idx];
    assign miss_start = (state_q == S_IDLE) && mem_read && !hit;
    assign fill_done  = (state_q == S_FILL) && pmem_resp;

    assign mem_resp     = (state_q == S_IDLE) && mem_read && hit;
    // Gate the word with mem_resp so the output stays X-free while the
    // data array still holds uninitialised lines.
    assign mem_rdata    = mem_resp ? sel_line[{req_word, 4'h0} +: 16] : 16'h0000;
    assign pmem_read    = (state_q == S_FILL);
    assign pmem_address = {fill_q, 4'h0};
    assign hit_count    = hit_cnt_q;
    assign miss_count   = miss_cnt_q;

    // Control FSM: the line address is captured on the miss and held for
    // the whole fill, so fetch-side changes during FILL cannot redirect it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fill_q  <= 12'h000;
            valid_q <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss_start) begin
                        fill_q  <= mem_address[15:4];
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (pmem_resp) begin
                        valid_q[fill_idx] <= 1'b1;
                        state_q           <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset. A reset during FILL clears state_q
    // asynchronously, so a late pmem_resp cannot write here.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[fill_idx]  <= fill_q[11:3];
            data_q[fill_idx] <= pmem_rdata;
        end
    end

    // Statistics counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else begin
            if (mem_resp && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'h0001;
            end
            if (miss_start && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache.
// Inputs change 1 ns after the rising edge. Combinational outputs are checked on the falling edge.
// Each scenario task does its own comparisons against hand-computed values.
module tb_icache;

    logic         clk;
    logic         rst_n;
    logic         mem_read;
    logic [15:0]  mem_address;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_read;
    logic [15:0]  pmem_address;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    int n_checks = 0;
    int n_errors = 0;

    icache dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line whose word k is base+k.
    function automatic logic [127:0] mk_line(input logic [15:0] base);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[16*k +: 16] = base + 16'(k);
        return l;
    endfunction

    // Drive a one-cycle fill pulse.
    task automatic pulse_fill(input logic [127:0] line);
        pmem_resp  = 1'b1;
        pmem_rdata = line;
        step();
        pmem_resp  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 1'b1; mem_address = 16'h0042;
        pmem_resp = 1'b0; pmem_rdata = '0;
        repeat (2) step();
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b0) begin n_errors++; $display("FAIL reset_mem_resp got=%b exp=0", mem_resp); end
        n_checks++; if (pmem_read !== 1'b0) begin n_errors++; $display("FAIL reset_pmem_read got=%b exp=0", pmem_read); end
        n_checks++; if (hit_count !== 16'h0) begin n_errors++; $display("FAIL reset_hit_count got=%h exp=0000", hit_count); end
        n_checks++; if (miss_count !== 16'h0) begin n_errors++; $display("FAIL reset_miss_count got=%h exp=0000", miss_count); end
        n_checks++; if ($isunknown(mem_rdata)) begin n_errors++; $display("FAIL reset_rdata_xfree got=%h exp=known", mem_rdata); end
        step();
        mem_read = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cold_miss();
        logic [127:0] l40;
        l40 = mk_line(16'hA000);
        l40[31:16] = 16'hBEEF;
        mem_read = 1'b1; mem_address = 16'h0042;
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b0) begin n_errors++; $display("FAIL cold_miss_resp got=%b exp=0", mem_resp); end
        step();
        n_checks++; if (miss_count !== 16'd1) begin n_errors++; $display("FAIL cold_miss_count got=%0d exp=1", miss_count); end
        n_checks++; if (pmem_read !== 1'b1) begin n_errors++; $display("FAIL cold_pmem_read got=%b exp=1", pmem_read); end
        n_checks++; if (pmem_address !== 16'h0040) begin n_errors++; $display("FAIL cold_pmem_addr got=%h exp=0040", pmem_address); end
        pulse_fill(l40);
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b1) begin n_errors++; $display("FAIL cold_fill_resp got=%b exp=1", mem_resp); end
        n_checks++; if (mem_rdata !== 16'hBEEF) begin n_errors++; $display("FAIL cold_fill_rdata got=%h exp=BEEF", mem_rdata); end
        n_checks++; if (pmem_read !== 1'b0) begin n_errors++; $display("FAIL cold_fill_pmem_read got=%b exp=0", pmem_read); end
        step();
        n_checks++; if (hit_count !== 16'd1) begin n_errors++; $display("FAIL cold_hit_count got=%0d exp=1", hit_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        for (int k = 0; k < 8; k++) begin
            mem_address = 16'h0040 + 16'(2 * k);
            exp = (k == 1) ? 16'hBEEF : 16'hA000 + 16'(k);
            @(negedge clk);
            n_checks++; if (mem_resp !== 1'b1) begin n_errors++; $display("FAIL b2b_resp[%0d] got=%b exp=1", k, mem_resp); end
            n_checks++; if (mem_rdata !== exp) begin n_errors++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", k, mem_rdata, exp); end
            n_checks++; if (pmem_read !== 1'b0) begin n_errors++; $display("FAIL b2b_pmem_read[%0d] got=%b exp=0", k, pmem_read); end
            step();
        end
        mem_read = 1'b0;
        n_checks++; if (hit_count !== 16'd9) begin n_errors++; $display("FAIL b2b_hit_count got=%0d exp=9", hit_count); end
    endtask

    task automatic test_conflict();
        logic [127:0] l40;
        l40 = mk_line(16'hA000);
        l40[31:16] = 16'hBEEF;
        mem_read = 1'b1; mem_address = 16'h00C0;
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b0) begin n_errors++; $display("FAIL conflict_c0_resp got=%b exp=0", mem_resp); end
        step();
        step();
        n_checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h00C0) begin n_errors++; $display("FAIL conflict_c0_fill got=%b/%h exp=1/00C0", pmem_read, pmem_address); end
        pulse_fill(mk_line(16'hC0C0));
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b1 || mem_rdata !== 16'hC0C0) begin n_errors++; $display("FAIL conflict_c0_hit got=%b/%h exp=1/C0C0", mem_resp, mem_rdata); end
        step();
        mem_address = 16'h0040;
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b0) begin n_errors++; $display("FAIL conflict_evicted_resp got=%b exp=0", mem_resp); end
        step();
        n_checks++; if (miss_count !== 16'd3) begin n_errors++; $display("FAIL conflict_miss_count got=%0d exp=3", miss_count); end
        n_checks++; if (pmem_address !== 16'h0040) begin n_errors++; $display("FAIL conflict_refill_addr got=%h exp=0040", pmem_address); end
        pulse_fill(l40);
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b1 || mem_rdata !== 16'hA000) begin n_errors++; $display("FAIL conflict_refill_hit got=%b/%h exp=1/A000", mem_resp, mem_rdata); end
        step();
        mem_read = 1'b0;
        n_checks++; if (hit_count !== 16'd11) begin n_errors++; $display("FAIL conflict_hit_count got=%0d exp=11", hit_count); end
    endtask

    task automatic test_addr_change();
        mem_read = 1'b1; mem_address = 16'h1230;
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b0) begin n_errors++; $display("FAIL chg_first_resp got=%b exp=0", mem_resp); end
        step();
        mem_address = 16'h5670;
        @(negedge clk);
        n_checks++; if (pmem_address !== 16'h1230) begin n_errors++; $display("FAIL chg_pmem_addr got=%h exp=1230", pmem_address); end
        n_checks++; if (mem_resp !== 1'b0) begin n_errors++; $display("FAIL chg_fill_resp got=%b exp=0", mem_resp); end
        step();
        n_checks++; if (pmem_address !== 16'h1230) begin n_errors++; $display("FAIL chg_pmem_addr2 got=%h exp=1230", pmem_address); end
        pulse_fill(mk_line(16'h1111));
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b0) begin n_errors++; $display("FAIL chg_5670_resp got=%b exp=0", mem_resp); end
        step();
        n_checks++; if (pmem_address !== 16'h5670 || miss_count !== 16'd5) begin n_errors++; $display("FAIL chg_second_fill got=%h/%0d exp=5670/5", pmem_address, miss_count); end
        pulse_fill(mk_line(16'h5670));
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b1 || mem_rdata !== 16'h5670) begin n_errors++; $display("FAIL chg_5670_hit got=%b/%h exp=1/5670", mem_resp, mem_rdata); end
        step();
        mem_address = 16'h1230;
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b1 || mem_rdata !== 16'h1111) begin n_errors++; $display("FAIL chg_1230_hit got=%b/%h exp=1/1111", mem_resp, mem_rdata); end
        step();
        mem_read = 1'b0;
        n_checks++; if (hit_count !== 16'd13) begin n_errors++; $display("FAIL chg_hit_count got=%0d exp=13", hit_count); end
    endtask

    task automatic test_read_drop();
        mem_read = 1'b1; mem_address = 16'h0200;
        step();
        mem_read = 1'b0;
        step();
        pulse_fill(mk_line(16'h2000));
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin n_errors++; $display("FAIL drop_no_resp got=%b/%b exp=0/0", mem_resp, pmem_read); end
        step();
        n_checks++; if (hit_count !== 16'd13 || miss_count !== 16'd6) begin n_errors++; $display("FAIL drop_counts got=%0d/%0d exp=13/6", hit_count, miss_count); end
        mem_read = 1'b1; mem_address = 16'h0204;
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b1 || mem_rdata !== 16'h2002) begin n_errors++; $display("FAIL drop_installed got=%b/%h exp=1/2002", mem_resp, mem_rdata); end
        step();
        mem_read = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        mem_read = 1'b1; mem_address = 16'h0100;
        step();
        n_checks++; if (pmem_read !== 1'b1) begin n_errors++; $display("FAIL rstfill_in_fill got=%b exp=1", pmem_read); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (pmem_read !== 1'b0) begin n_errors++; $display("FAIL rstfill_pmem_read got=%b exp=0", pmem_read); end
        n_checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin n_errors++; $display("FAIL rstfill_counts got=%h/%h exp=0000/0000", hit_count, miss_count); end
        mem_read = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        pulse_fill(mk_line(16'hDEAD));
        mem_read = 1'b1; mem_address = 16'h0100;
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b0) begin n_errors++; $display("FAIL rstfill_still_miss got=%b exp=0", mem_resp); end
        step();
        n_checks++; if (pmem_read !== 1'b1 || miss_count !== 16'd1) begin n_errors++; $display("FAIL rstfill_refetch got=%b/%0d exp=1/1", pmem_read, miss_count); end
        pulse_fill(mk_line(16'h0100));
        @(negedge clk);
        n_checks++; if (mem_resp !== 1'b1 || mem_rdata !== 16'h0100) begin n_errors++; $display("FAIL rstfill_hit got=%b/%h exp=1/0100", mem_resp, mem_rdata); end
    endtask

    // Continues from a hit on 16'h0100 with hit_count=0.
    task automatic test_saturation();
        repeat (65534) step();
        n_checks++; if (hit_count !== 16'hFFFE) begin n_errors++; $display("FAIL sat_near got=%h exp=FFFE", hit_count); end
        repeat (5) step();
        n_checks++; if (hit_count !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold got=%h exp=FFFF", hit_count); end
        n_checks++; if (miss_count !== 16'd1 || mem_resp !== 1'b1) begin n_errors++; $display("FAIL sat_other got=%0d/%b exp=1/1", miss_count, mem_resp); end
        mem_read = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_addr_change();
        test_read_drop();
        test_reset_mid_fill();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have no parameters: 8 lines, direct-mapped, 16-byte lines (8 x 16-bit words), read-only.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 mem_read  input  1  fetch-side read request, held until mem_resp.
REQ-005 mem_address  input  16  fetch-side byte address; bit 0 ignored.
REQ-006 mem_resp  output  1  fetch-side read complete, one-cycle pulse per served request.
REQ-007 mem_rdata  output  16  instruction word; valid only while mem_resp=1.
REQ-008 pmem_read  output  1  line-fill request to physical memory.
REQ-009 pmem_address  output  16  line-aligned fill address, bits [3:0]=0.
REQ-010 pmem_resp  input  1  fill data valid, single-cycle pulse.
REQ-011 pmem_rdata  input  128  fill line; word k at bits [16k+15:16k].
REQ-012 hit_count  output  16  saturating count of hits served.
REQ-013 miss_count  output  16  saturating count of misses detected.

Function
REQ-014 Address split SHALL be: tag=[15:7] (9 b), index=[6:4] (3 b), word=[3:1] (3 b).
REQ-015 Storage SHALL be 8 entries of {valid, tag[8:0], data[127:0]}.
REQ-016 FSM SHALL have exactly two states: IDLE and FILL.
REQ-017 IDLE, mem_read=1, valid[index] and tag match -> hit: mem_resp=1 combinationally same cycle, mem_rdata=data[index] word[word]; stay IDLE.
REQ-018 IDLE, mem_read=1, miss -> mem_resp=0; latch mem_address[15:4] into fill register; go FILL next edge.
REQ-019 FILL: pmem_read=1, pmem_address={fill register,4'b0}; mem_resp=0 regardless of mem_read.
REQ-020 FILL and pmem_resp=1 -> write pmem_rdata, valid=1, tag into latched index; go IDLE next edge.
REQ-021 Miss latency SHALL be: request cycle + fill cycles + 1 IDLE hit cycle; mem_resp asserted in the first IDLE cycle after fill.
REQ-022 mem_address/mem_read changes during FILL SHALL NOT alter pmem_address; fill always completes and installs the latched line.
REQ-023 mem_read deasserted during FILL -> line still installed, no mem_resp generated.
REQ-024 Fill replaces any valid line at the index (direct-mapped eviction, no writeback).
REQ-025 pmem_resp while IDLE SHALL be ignored.
REQ-026 hit_count SHALL increment once per cycle with mem_resp=1; miss_count once per IDLE->FILL transition; both hold at 16'hFFFF.
REQ-027 Outside mem_resp=1, mem_rdata SHALL be don't-care but X-free after reset.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=IDLE, all valid=0, fill register=0, hit_count=0, miss_count=0, pmem_read=0, mem_resp=0.
REQ-029 Reset asserted during FILL SHALL abandon the fill; a pmem_resp arriving after reset release SHALL be ignored.
REQ-030 Tag/data arrays need not be cleared on reset.

Verification
REQ-031 Cold miss: reset, mem_read=1, addr=16'h0042 -> miss_count=1, pmem_read=1 with pmem_address=16'h0040; pmem_resp with word1=16'hBEEF -> next cycle mem_resp=1, mem_rdata=16'hBEEF, hit_count=1.
REQ-032 Back-to-back hits: after REQ-031, addr 16'h0040..16'h004E in consecutive cycles -> mem_resp=1 each cycle, correct words, no pmem_read, hit_count=9.
REQ-033 Conflict eviction: fill 16'h0040, then read 16'h00C0 (same index 4, tag 1) -> miss, fill, then 16'h0040 misses again; miss_count=3.
REQ-034 Address change mid-fill: miss on 16'h1230, change addr to 16'h5670 during FILL -> pmem_address stays 16'h1230; after fill, 16'h5670 misses, second fill at 16'h5670.
REQ-035 Reset mid-fill: miss on 16'h0100, assert rst_n=0 in FILL -> pmem_read=0 same cycle; release, pulse pmem_resp -> no install; 16'h0100 still misses.
REQ-036 Saturation: force 65536 hits -> hit_count holds 16'hFFFF.
